// File: rtl/led_scan_ctrl_if.sv
// Bus between a display data source and led_scan_ctrl: digit data in, LED decoder
// control and anode drive out.
interface led_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      i_en;
  logic                      i_load;
  logic [4*NUM_DIGITS-1:0]   i_data;
  logic [NUM_DIGITS-1:0]     i_dp;
  logic                      i_lzb;
  logic [4:0]                o_dig_ctrl;
  logic [NUM_DIGITS-1:0]     o_digit_an;
  logic                      o_frame;

  modport master (
    output i_en, i_load, i_data, i_dp, i_lzb,
    input  o_dig_ctrl, o_digit_an, o_frame
  );

  modport slave (
    input  i_en, i_load, i_data, i_dp, i_lzb,
    output o_dig_ctrl, o_digit_an, o_frame
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-consistent shadow data,
// per-slot anti-ghosting dead time and optional leading-zero blanking.
module led_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  led_scan_ctrl_if.slave bus
);
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntDead = CntW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, active_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                    lzb_q;
  logic                    frame_q;

  logic slot_end, wrap;
  assign slot_end = (cnt_q == CntLast);
  assign wrap     = bus.i_en && slot_end && (idx_q == IdxLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      lzb_q         <= 1'b0;
      frame_q       <= 1'b0;
    end else begin
      // The pulse marks the first cycle of digit 0 reached by scanning, not by reset.
      frame_q <= wrap;
      lzb_q   <= bus.i_lzb;
      if (bus.i_load) begin
        shadow_data_q <= bus.i_data;
        shadow_dp_q   <= bus.i_dp;
      end
      if (wrap) begin
        active_data_q <= bus.i_load ? bus.i_data : shadow_data_q;
        active_dp_q   <= bus.i_load ? bus.i_dp   : shadow_dp_q;
      end
      if (!bus.i_en) begin
        cnt_q <= '0;
      end else if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // blank[k]: digit k and everything above it carry neither a nibble nor a dp.
  logic [NUM_DIGITS-1:0] blank;
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_data_q[4*k +: 4] == 4'h0) && !active_dp_q[k];
      if (k != 0) blank[k] = zero_above;
    end
  end

  logic [NUM_DIGITS-1:0] digit_an;
  always_comb begin
    digit_an = '1;
    if ((cnt_q >= CntDead) && !(lzb_q && blank[idx_q])) digit_an[idx_q] = 1'b0;
  end

  assign bus.o_dig_ctrl = {active_dp_q[idx_q], active_data_q[4*idx_q +: 4]};
  assign bus.o_digit_an = digit_an;
  assign bus.o_frame    = frame_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a frame-position model.
module tb_led_scan_ctrl;
  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 8;
  localparam int unsigned DC    = 2;
  localparam int unsigned FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  led_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEAD_CYCLES(DC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame (digit*SD + slot cycle) plus nibble arrays.
  int         m_pos = 0;
  logic [3:0] m_sh[ND], m_act[ND];
  logic       m_shdp[ND], m_actdp[ND];
  logic       m_lzb = 1'b0, m_frame = 1'b0;
  bit         chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0;
      for (int j = 0; j < ND; j++) begin
        m_sh[j] = 4'h0; m_act[j] = 4'h0; m_shdp[j] = 1'b0; m_actdp[j] = 1'b0;
      end
      m_lzb   = 1'b0;
      m_frame = 1'b0;
    end else begin
      m_frame = bus.i_en && (m_pos == FRAME - 1);
      for (int j = 0; j < ND; j++) begin
        if (m_frame) begin
          m_act[j]   = bus.i_load ? bus.i_data[4*j +: 4] : m_sh[j];
          m_actdp[j] = bus.i_load ? bus.i_dp[j] : m_shdp[j];
        end
        if (bus.i_load) begin
          m_sh[j]   = bus.i_data[4*j +: 4];
          m_shdp[j] = bus.i_dp[j];
        end
      end
      m_lzb = bus.i_lzb;
      m_pos = bus.i_en ? (m_pos + 1) % FRAME : (m_pos / SD) * SD;
    end
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int k, c, msd;
      logic [ND-1:0] an_e;
      k   = m_pos / SD;
      c   = m_pos % SD;
      msd = 0;
      for (int j = 0; j < ND; j++) if (m_act[j] != 4'h0 || m_actdp[j]) msd = j;
      an_e = '1;
      if (c >= DC && !(m_lzb && k > msd)) an_e[k] = 1'b0;
      check("model_dig_ctrl", {3'b0, bus.o_dig_ctrl}, {3'b0, m_actdp[k], m_act[k]});
      check("model_digit_an", {4'b0, bus.o_digit_an}, {4'b0, an_e});
      check("model_frame", {7'b0, bus.o_frame}, {7'b0, m_frame});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] mask;
    bus.i_en = 1'b1; bus.i_load = 1'b0; bus.i_data = '0; bus.i_dp = '0; bus.i_lzb = 1'b0;

    // Reset and first frame
    tick(3);
    check("rst_an", {4'b0, bus.o_digit_an}, 8'h0F);
    check("rst_dig", {3'b0, bus.o_dig_ctrl}, 8'h00);
    check("rst_frame", {7'b0, bus.o_frame}, 8'h00);
    rst = 1'b0;
    check("first_cycle_frame", {7'b0, bus.o_frame}, 8'h00);
    tick(2);
    check("dig0_lit", {4'b0, bus.o_digit_an}, 8'h0E);
    tick(30);
    check("first_frame_pulse", {7'b0, bus.o_frame}, 8'h01);
    check("frame_dead", {4'b0, bus.o_digit_an}, 8'h0F);

    // Shadow load becomes active only at the wrap
    bus.i_data = 16'h1234; bus.i_dp = 4'b0100; bus.i_load = 1'b1;
    tick(1); bus.i_load = 1'b0;
    check("old_data_held", {3'b0, bus.o_dig_ctrl}, 8'h00);
    tick(31);
    check("load_frame", {7'b0, bus.o_frame}, 8'h01);
    check("load_idx0", {3'b0, bus.o_dig_ctrl}, 8'h04);
    tick(2);
    check("load_an0", {4'b0, bus.o_digit_an}, 8'h0E);
    tick(8);
    check("load_idx1", {3'b0, bus.o_dig_ctrl}, 8'h03);
    tick(8);
    check("load_idx2", {3'b0, bus.o_dig_ctrl}, 8'h12);
    tick(8);
    check("load_idx3", {3'b0, bus.o_dig_ctrl}, 8'h01);

    // Load on the wrap cycle bypasses the shadow
    tick(5);
    bus.i_data = 16'hABCD; bus.i_dp = '0; bus.i_load = 1'b1;
    tick(1); bus.i_load = 1'b0;
    check("bypass_dig", {3'b0, bus.o_dig_ctrl}, 8'h0D);
    check("bypass_frame", {7'b0, bus.o_frame}, 8'h01);

    // Leading-zero blanking
    bus.i_lzb = 1'b1; bus.i_data = 16'h0005; bus.i_dp = '0; bus.i_load = 1'b1;
    tick(1); bus.i_load = 1'b0;
    tick(31);
    check("lzb_dig0", {3'b0, bus.o_dig_ctrl}, 8'h05);
    tick(2);
    check("lzb_an0", {4'b0, bus.o_digit_an}, 8'h0E);
    tick(8);
    check("lzb_an1_blank", {4'b0, bus.o_digit_an}, 8'h0F);
    bus.i_dp = 4'b0100; bus.i_load = 1'b1;
    tick(1); bus.i_load = 1'b0;
    tick(31);
    check("lzb_dp_dig1", {3'b0, bus.o_dig_ctrl}, 8'h00);
    check("lzb_dp_an1", {4'b0, bus.o_digit_an}, 8'h0D);
    tick(8);
    check("lzb_dp_dig2", {3'b0, bus.o_dig_ctrl}, 8'h10);
    check("lzb_dp_an2", {4'b0, bus.o_digit_an}, 8'h0B);
    tick(8);
    check("lzb_dp_an3_blank", {4'b0, bus.o_digit_an}, 8'h0F);

    // All-zero data: only digit 0 lit
    bus.i_data = 16'h0000; bus.i_dp = '0; bus.i_load = 1'b1;
    tick(1); bus.i_load = 1'b0;
    tick(7);
    check("zero_an0", {4'b0, bus.o_digit_an}, 8'h0E);
    check("zero_dig0", {3'b0, bus.o_dig_ctrl}, 8'h00);
    tick(8);
    check("zero_an1_blank", {4'b0, bus.o_digit_an}, 8'h0F);

    // Enable drop mid-SHOW on digit 2, then reset mid-SHOW
    bus.i_lzb = 1'b0;
    tick(9);
    check("en_show_an2", {4'b0, bus.o_digit_an}, 8'h0B);
    bus.i_en = 1'b0;
    tick(1);
    check("en_off_an", {4'b0, bus.o_digit_an}, 8'h0F);
    check("en_off_frame", {7'b0, bus.o_frame}, 8'h00);
    tick(4);
    bus.i_en = 1'b1;
    check("reen_dead0", {4'b0, bus.o_digit_an}, 8'h0F);
    tick(1);
    check("reen_dead1", {4'b0, bus.o_digit_an}, 8'h0F);
    tick(1);
    check("reen_show", {4'b0, bus.o_digit_an}, 8'h0B);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_an", {4'b0, bus.o_digit_an}, 8'h0F);
    check("midrst_dig", {3'b0, bus.o_dig_ctrl}, 8'h00);
    check("midrst_frame", {7'b0, bus.o_frame}, 8'h00);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      bus.i_en   = ($urandom_range(0, 7) != 0);
      bus.i_load = ($urandom_range(0, 11) == 0);
      mask       = 16'hFFFF >> (4 * $urandom_range(0, 4));
      bus.i_data = 16'($urandom) & mask;
      bus.i_dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) bus.i_lzb = ~bus.i_lzb;
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
